// File: rtl/blit_pkg.sv
// Shared definitions for the blitter data adder: operand selects, adder modes,
// register load codes and the 16-bit lane type.
package blit_pkg;

  typedef logic [15:0] lane_t;

  localparam logic [2:0] DADD_ASEL_PATD  = 3'b000;
  localparam logic [2:0] DADD_ASEL_PATF  = 3'b001;
  localparam logic [2:0] DADD_ASEL_SRCZ1 = 3'b010;
  localparam logic [2:0] DADD_ASEL_SRCZ2 = 3'b011;
  localparam logic [2:0] DADD_ASEL_SRCD  = 3'b100;

  localparam logic [2:0] DADD_BSEL_IINT  = 3'b000;
  localparam logic [2:0] DADD_BSEL_IFRAC = 3'b001;
  localparam logic [2:0] DADD_BSEL_ZINT  = 3'b010;
  localparam logic [2:0] DADD_BSEL_ZFRAC = 3'b011;
  localparam logic [2:0] DADD_BSEL_SHADE = 3'b100;

  localparam logic [2:0] DADD_MODE_INT   = 3'b000;
  localparam logic [2:0] DADD_MODE_INTEN = 3'b001;
  localparam logic [2:0] DADD_MODE_SSAT  = 3'b010;
  localparam logic [2:0] DADD_MODE_FRAC  = 3'b100;
  localparam logic [2:0] DADD_MODE_SHADE = 3'b101;

  localparam logic [3:0] LD_PATD_LO  = 4'd0;
  localparam logic [3:0] LD_PATD_HI  = 4'd1;
  localparam logic [3:0] LD_PATF_LO  = 4'd2;
  localparam logic [3:0] LD_PATF_HI  = 4'd3;
  localparam logic [3:0] LD_SRCZ1_LO = 4'd4;
  localparam logic [3:0] LD_SRCZ1_HI = 4'd5;
  localparam logic [3:0] LD_SRCZ2_LO = 4'd6;
  localparam logic [3:0] LD_SRCZ2_HI = 4'd7;
  localparam logic [3:0] LD_IINC     = 4'd8;
  localparam logic [3:0] LD_ZINC     = 4'd9;

endpackage

// File: rtl/blit_dadd_if.sv
// Control/data bundle between the data-control decode and the data adder.
interface blit_dadd_if;
  logic [31:0] gpu_din;
  logic        gpu_ld;
  logic [3:0]  ld_sel;
  logic        add_en;
  logic [2:0]  daddasel;
  logic [2:0]  daddbsel;
  logic [2:0]  daddmode;
  logic        daddq_sel;
  logic [63:0] srcd;
  logic [63:0] dadd_q;
  logic        dadd_vld;
  logic [63:0] patd;
  logic [63:0] srcz1;

  modport master (
    output gpu_din, gpu_ld, ld_sel, add_en, daddasel, daddbsel, daddmode, daddq_sel, srcd,
    input  dadd_q, dadd_vld, patd, srcz1
  );

  modport slave (
    input  gpu_din, gpu_ld, ld_sel, add_en, daddasel, daddbsel, daddmode, daddq_sel, srcd,
    output dadd_q, dadd_vld, patd, srcz1
  );
endinterface

// File: rtl/dadd_lane.sv
// One 16-bit adder lane: wrap, fraction (carry-out), 8-bit intensity and signed
// 16-bit saturating adds. Purely combinational.
module dadd_lane
  import blit_pkg::*;
(
  input  lane_t      a,
  input  lane_t      b,
  input  logic       cin,
  input  logic [2:0] mode,
  output lane_t      sum,
  output logic       cout
);

  function automatic logic [7:0] sat_u8(input logic signed [17:0] v);
    if (v < 18'sd0)        return 8'h00;
    else if (v > 18'sd255) return 8'hFF;
    else                   return v[7:0];
  endfunction

  function automatic lane_t sat_s16(input logic signed [17:0] v);
    if (v > 18'sd32767)       return 16'h7FFF;
    else if (v < -18'sd32768) return 16'h8000;
    else                      return v[15:0];
  endfunction

  logic              cin_eff;
  logic [16:0]       wide;
  logic signed [17:0] ext_b;
  logic signed [17:0] cin_s;
  logic signed [17:0] lo_sum;
  logic signed [17:0] full_sum;

  always_comb begin
    // Only the integer-step modes chain the carry from the preceding fraction add
    cin_eff  = (mode == DADD_MODE_INT) || (mode == DADD_MODE_INTEN) || (mode == DADD_MODE_SSAT)
               ? cin : 1'b0;
    wide     = {1'b0, a} + {1'b0, b} + {16'b0, cin_eff};
    ext_b    = {{2{b[15]}}, b};
    cin_s    = {17'b0, cin_eff};
    lo_sum   = $signed({10'b0, a[7:0]}) + ext_b + cin_s;
    full_sum = $signed({{2{a[15]}}, a}) + ext_b + cin_s;
    cout     = wide[16];
    case (mode)
      DADD_MODE_INTEN,
      DADD_MODE_SHADE: sum = {a[15:8], sat_u8(lo_sum)};
      DADD_MODE_SSAT:  sum = sat_s16(full_sum);
      default:         sum = wide[15:0];
    endcase
  end

endmodule

// File: rtl/blit_dadd.sv
// Blitter data adder: accumulator/increment registers, operand muxes, four
// parallel lanes and the registered sum with accumulator write-back.
module blit_dadd
  import blit_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic         sys_clk,
  input  logic         reset,
  blit_dadd_if.slave   bus
);

  localparam int PW = LANES * 16;

  logic [PW-1:0]    patd_acc, patf_acc, srcz1_acc, srcz2_acc;
  logic [23:0]      iinc;
  logic [31:0]      zinc;
  logic [LANES-1:0] carry;
  logic [PW-1:0]    sum_p1;
  logic             vld_p1;

  logic [PW-1:0]    a_op;
  lane_t            b_op;
  logic [PW-1:0]    sum_p0;
  logic [LANES-1:0] cout_p0;

  always_comb begin
    case (bus.daddasel)
      DADD_ASEL_PATD:  a_op = patd_acc;
      DADD_ASEL_PATF:  a_op = patf_acc;
      DADD_ASEL_SRCZ1: a_op = srcz1_acc;
      DADD_ASEL_SRCZ2: a_op = srcz2_acc;
      default:         a_op = bus.srcd;
    endcase
    case (bus.daddbsel)
      DADD_BSEL_IFRAC: b_op = iinc[15:0];
      DADD_BSEL_ZINT:  b_op = zinc[31:16];
      DADD_BSEL_ZFRAC: b_op = zinc[15:0];
      default:         b_op = {{8{iinc[23]}}, iinc[23:16]};
    endcase
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    dadd_lane u_lane (
      .a    (a_op[16*i +: 16]),
      .b    (b_op),
      .cin  (carry[i]),
      .mode (bus.daddmode),
      .sum  (sum_p0[16*i +: 16]),
      .cout (cout_p0[i])
    );
  end

  // ---- p0 -> p1: register sum, write back, update carries, take GPU loads
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      patd_acc  <= '0;
      patf_acc  <= '0;
      srcz1_acc <= '0;
      srcz2_acc <= '0;
      iinc      <= '0;
      zinc      <= '0;
      carry     <= '0;
      sum_p1    <= '0;
      vld_p1    <= 1'b0;
    end else begin
      vld_p1 <= bus.add_en;
      if (bus.add_en) begin
        sum_p1 <= sum_p0;
        case (bus.daddmode)
          DADD_MODE_INT, DADD_MODE_INTEN, DADD_MODE_SSAT: carry <= '0;
          DADD_MODE_SHADE:                                carry <= carry;
          default:                                        carry <= cout_p0;
        endcase
        if (bus.daddq_sel && !bus.daddasel[2]) begin
          case (bus.daddasel[1:0])
            2'd0:    patd_acc  <= sum_p0;
            2'd1:    patf_acc  <= sum_p0;
            2'd2:    srcz1_acc <= sum_p0;
            default: srcz2_acc <= sum_p0;
          endcase
        end
      end
      // Later assignment lets a GPU load override the write-back on its half only
      if (bus.gpu_ld) begin
        case (bus.ld_sel)
          LD_PATD_LO:  patd_acc[31:0]   <= bus.gpu_din;
          LD_PATD_HI:  patd_acc[63:32]  <= bus.gpu_din;
          LD_PATF_LO:  patf_acc[31:0]   <= bus.gpu_din;
          LD_PATF_HI:  patf_acc[63:32]  <= bus.gpu_din;
          LD_SRCZ1_LO: srcz1_acc[31:0]  <= bus.gpu_din;
          LD_SRCZ1_HI: srcz1_acc[63:32] <= bus.gpu_din;
          LD_SRCZ2_LO: srcz2_acc[31:0]  <= bus.gpu_din;
          LD_SRCZ2_HI: srcz2_acc[63:32] <= bus.gpu_din;
          LD_IINC:     iinc             <= bus.gpu_din[23:0];
          LD_ZINC:     zinc             <= bus.gpu_din;
          default: ;
        endcase
      end
    end
  end

  assign bus.dadd_q   = sum_p1;
  assign bus.dadd_vld = vld_p1;
  assign bus.patd     = patd_acc;
  assign bus.srcz1    = srcz1_acc;

endmodule
